// File: rtl/round_control_pkg.sv
// round_control_pkg
//   Shared definitions for the memory-tile round sequencer:
//   - MAX_LEN / SEQ_W : longest round and width of the packed tile sequence
//   - state_t         : sequencer state encoding
//   - tile()          : extracts tile i from the packed sequence, MSB at the lower bit index
package round_control_pkg;

  localparam int MAX_LEN = 9;
  localparam int SEQ_W   = 2 * MAX_LEN;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GAP,
    S_SHOW,
    S_PREP,
    S_WAIT,
    S_STROBE,
    S_EVAL,
    S_RELEASE,
    S_WIN,
    S_LOSE
  } state_t;

  // Tile i occupies bits [2i+1:2i], but bit 2i is the tile MSB.
  function automatic logic [1:0] tile(input logic [SEQ_W-1:0] seq, input logic [3:0] idx);
    logic [4:0] b;
    b = {idx, 1'b0};
    return {seq[b], seq[b + 5'd1]};
  endfunction

endpackage

// File: rtl/round_control_if.sv
// round_control_if
//   Link between the round sequencer and the player-input/check datapath.
//   seq_counter  : tile index under playback or under check
//   playerEN     : enables press capture in the datapath
//   checkEN      : one-cycle compare strobe
//   player_input : a press has been captured under playerEN
//   check        : registered match result, valid one cycle after checkEN
//   master = sequencer side, slave = datapath side.
interface round_control_if;
  logic [3:0] seq_counter;
  logic       playerEN;
  logic       checkEN;
  logic       player_input;
  logic       check;

  modport master (
    output seq_counter, playerEN, checkEN,
    input  player_input, check
  );

  modport slave (
    input  seq_counter, playerEN, checkEN,
    output player_input, check
  );
endinterface

// File: rtl/round_control_phase_timer.sv
// phase_timer
//   Cycle counter for the round sequencer. Counts cycles spent in the current state;
//   i_clear restarts it at 0 on the next cycle (asserted on every state change).
//   Each compare output is high during the K-th and later cycles of a state, so a
//   state that leaves on the compare lasts exactly K cycles.
//   Ports: clk, reset (sync, active-high), i_clear,
//          o_ge_gap / o_ge_show / o_ge_timeout.
module phase_timer #(
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_ge_gap,
  output logic o_ge_show,
  output logic o_ge_timeout
);

  localparam int W = $clog2(GAP_CYCLES + SHOW_CYCLES + TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] GAP_LAST  = W'(GAP_CYCLES - 1);
  localparam logic [W-1:0] SHOW_LAST = W'(SHOW_CYCLES - 1);
  localparam logic [W-1:0] TOUT_LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  // Saturates so a long stay in IDLE/WIN/LOSE never wraps the count.
  always_ff @(posedge clk) begin
    if (reset || i_clear) r_count <= '0;
    else if (r_count != '1) r_count <= r_count + 1'b1;
  end

  assign o_ge_gap     = (r_count >= GAP_LAST);
  assign o_ge_show    = (r_count >= SHOW_LAST);
  assign o_ge_timeout = (r_count >= TOUT_LAST);

endmodule

// File: rtl/round_control.sv
// round_control
//   Round sequencer for the memory-tile game: plays back the first round_len tiles,
//   then lets the datapath capture and check one press per tile. Grows the round on
//   success; ends on a wrong tile, a press timeout or a completed MAX_LEN round.
//   Ports: clk, reset (sync, active-high), i_start, i_seq (packed tile sequence),
//          dp (datapath link, master side), o_show_on, o_show_tile, o_round_len,
//          o_win, o_lose. All outputs are registered.
module round_control
  import round_control_pkg::*;
#(
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [SEQ_W-1:0] i_seq,
  round_control_if.master  dp,
  output logic             o_show_on,
  output logic [1:0]       o_show_tile,
  output logic [3:0]       o_round_len,
  output logic             o_win,
  output logic             o_lose
);

  state_t     r_state, w_state_n;
  logic [3:0] r_seq_counter, w_cnt_n;
  logic [3:0] r_round_len, w_len_n;
  logic       r_win, w_win_n;
  logic       r_lose, w_lose_n;
  logic       r_player_en, r_check_en, r_show_on;
  logic [1:0] r_show_tile;
  logic       w_ge_gap, w_ge_show, w_ge_timeout;
  logic       w_more;

  phase_timer #(
    .GAP_CYCLES    (GAP_CYCLES),
    .SHOW_CYCLES   (SHOW_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_state_n != r_state),
    .o_ge_gap    (w_ge_gap),
    .o_ge_show   (w_ge_show),
    .o_ge_timeout(w_ge_timeout)
  );

  // More tiles remain in the current round after the one at seq_counter.
  assign w_more = (r_seq_counter < (r_round_len - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_seq_counter;
    w_len_n   = r_round_len;
    w_win_n   = r_win;
    w_lose_n  = r_lose;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (i_start) begin
          w_state_n = S_GAP;
          w_cnt_n   = 4'd0;
          w_len_n   = 4'd1;
          w_win_n   = 1'b0;
          w_lose_n  = 1'b0;
        end
      end
      S_GAP:  if (w_ge_gap) w_state_n = S_SHOW;
      S_SHOW: begin
        if (w_ge_show) begin
          if (w_more) begin
            w_cnt_n   = r_seq_counter + 4'd1;
            w_state_n = S_GAP;
          end else begin
            w_cnt_n   = 4'd0;
            w_state_n = S_PREP;
          end
        end
      end
      S_PREP: if (w_ge_gap) w_state_n = S_WAIT;
      S_WAIT: begin
        // A press in the final timeout cycle still counts.
        if (dp.player_input) begin
          w_state_n = S_STROBE;
        end else if (w_ge_timeout) begin
          w_state_n = S_LOSE;
          w_lose_n  = 1'b1;
        end
      end
      S_STROBE: w_state_n = S_EVAL;
      S_EVAL: begin
        if (!dp.check) begin
          w_state_n = S_LOSE;
          w_lose_n  = 1'b1;
        end else if (w_more) begin
          w_cnt_n   = r_seq_counter + 4'd1;
          w_state_n = S_RELEASE;
        end else if (r_round_len == 4'(MAX_LEN)) begin
          w_state_n = S_WIN;
          w_win_n   = 1'b1;
        end else begin
          w_len_n   = r_round_len + 4'd1;
          w_cnt_n   = 4'd0;
          w_state_n = S_GAP;
        end
      end
      S_RELEASE: w_state_n = S_WAIT;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq_counter <= 4'd0;
      r_round_len   <= 4'd1;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
      r_player_en   <= 1'b0;
      r_check_en    <= 1'b0;
      r_show_on     <= 1'b0;
    end else begin
      r_seq_counter <= w_cnt_n;
      r_round_len   <= w_len_n;
      r_win         <= w_win_n;
      r_lose        <= w_lose_n;
      r_player_en   <= (w_state_n == S_WAIT);
      r_check_en    <= (w_state_n == S_STROBE);
      r_show_on     <= (w_state_n == S_SHOW);
    end
  end

  // Tile value only matters while o_show_on is high, so it carries no reset.
  always_ff @(posedge clk) begin
    r_show_tile <= tile(i_seq, w_cnt_n);
  end

  assign dp.seq_counter = r_seq_counter;
  assign dp.playerEN    = r_player_en;
  assign dp.checkEN     = r_check_en;
  assign o_show_on      = r_show_on;
  assign o_show_tile    = r_show_tile;
  assign o_round_len    = r_round_len;
  assign o_win          = r_win;
  assign o_lose         = r_lose;

endmodule

// File: tb/tb_round_control.sv
module tb_round_control;
  import round_control_pkg::*;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TOUT = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             i_start = 1'b0;
  logic [SEQ_W-1:0] i_seq = '0;
  logic             o_show_on;
  logic [1:0]       o_show_tile;
  logic [3:0]       o_round_len;
  logic             o_win, o_lose;

  round_control_if rc_if ();

  round_control #(
    .SHOW_CYCLES   (SHOW),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_seq      (i_seq),
    .dp         (rc_if),
    .o_show_on  (o_show_on),
    .o_show_tile(o_show_tile),
    .o_round_len(o_round_len),
    .o_win      (o_win),
    .o_lose     (o_lose)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] tiles [MAX_LEN];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model holds the sequence as a tile list; the packed bus is built from it.
  task automatic load_seq(input logic [1:0] t0, input bit force0);
    logic [SEQ_W-1:0] s;
    s = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      tiles[k] = 2'($urandom_range(0, 3));
      if (k == 0 && force0) tiles[k] = t0;
      s = s | (SEQ_W'({tiles[k][0], tiles[k][1]}) << (2 * k));
    end
    i_seq = s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_start = 1'b0;
    rc_if.player_input = 1'b0;
    rc_if.check = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Expected playback of a round of len tiles, starting at the first GAP cycle.
  task automatic play_back(input int len);
    for (int k = 0; k < len; k++) begin
      for (int g = 0; g < GAP; g++) begin
        n_tests++;
        if (o_show_on !== 1'b0 || rc_if.playerEN !== 1'b0 || rc_if.checkEN !== 1'b0) begin
          n_fail++;
          $display("FAIL gap len=%0d k=%0d: show_on=%b playerEN=%b checkEN=%b, required 0 0 0",
                   len, k, o_show_on, rc_if.playerEN, rc_if.checkEN);
        end
        step();
      end
      for (int s = 0; s < SHOW; s++) begin
        n_tests++;
        if (o_show_on !== 1'b1 || o_show_tile !== tiles[k] || rc_if.seq_counter !== 4'(k)) begin
          n_fail++;
          $display("FAIL show len=%0d k=%0d: show_on=%b tile=%b cnt=%0d, required 1 %b %0d",
                   len, k, o_show_on, o_show_tile, rc_if.seq_counter, tiles[k], k);
        end
        step();
      end
    end
    for (int g = 0; g < GAP; g++) begin
      n_tests++;
      if (o_show_on !== 1'b0 || rc_if.playerEN !== 1'b0) begin
        n_fail++;
        $display("FAIL prep len=%0d: show_on=%b playerEN=%b, required 0 0",
                 len, o_show_on, rc_if.playerEN);
      end
      step();
    end
    n_tests++;
    if (rc_if.playerEN !== 1'b1 || rc_if.seq_counter !== 4'd0 || o_round_len !== 4'(len)) begin
      n_fail++;
      $display("FAIL wait_entry len=%0d: playerEN=%b cnt=%0d round_len=%0d, required 1 0 %0d",
               len, rc_if.playerEN, rc_if.seq_counter, o_round_len, len);
    end
  endtask

  // One press for tile j after `delay` idle WAIT cycles; ends on the cycle after EVAL.
  task automatic press(input int j, input int delay, input bit good);
    for (int i = 0; i <= delay; i++) begin
      n_tests++;
      if (rc_if.playerEN !== 1'b1 || o_lose !== 1'b0 || rc_if.seq_counter !== 4'(j)) begin
        n_fail++;
        $display("FAIL wait j=%0d i=%0d: playerEN=%b lose=%b cnt=%0d, required 1 0 %0d",
                 j, i, rc_if.playerEN, o_lose, rc_if.seq_counter, j);
      end
      if (i < delay) step();
    end
    rc_if.player_input = 1'b1;
    step();
    n_tests++;
    if (rc_if.checkEN !== 1'b1 || rc_if.playerEN !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe j=%0d: checkEN=%b playerEN=%b, required 1 0",
               j, rc_if.checkEN, rc_if.playerEN);
    end
    rc_if.check = good;
    step();
    n_tests++;
    if (rc_if.checkEN !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_width j=%0d: checkEN=%b, required 0", j, rc_if.checkEN);
    end
    step();
  endtask

  // Answer a round; bad = index of the wrong tile, or -1 for all correct.
  task automatic answer_round(input int len, input int bad);
    for (int j = 0; j < len; j++) begin
      press(j, $urandom_range(0, TOUT - 1), j != bad);
      if (j == bad) begin
        n_tests++;
        if (o_lose !== 1'b1 || rc_if.playerEN !== 1'b0 || rc_if.checkEN !== 1'b0) begin
          n_fail++;
          $display("FAIL wrong_tile len=%0d j=%0d: lose=%b playerEN=%b checkEN=%b, required 1 0 0",
                   len, j, o_lose, rc_if.playerEN, rc_if.checkEN);
        end
        rc_if.player_input = 1'b0;
        return;
      end else if (j < len - 1) begin
        n_tests++;
        if (rc_if.playerEN !== 1'b0 || rc_if.seq_counter !== 4'(j + 1) || o_lose !== 1'b0) begin
          n_fail++;
          $display("FAIL release len=%0d j=%0d: playerEN=%b cnt=%0d lose=%b, required 0 %0d 0",
                   len, j, rc_if.playerEN, rc_if.seq_counter, o_lose, j + 1);
        end
        rc_if.player_input = 1'b0;
        step();
      end else if (len == MAX_LEN) begin
        n_tests++;
        if (o_win !== 1'b1 || o_round_len !== 4'(MAX_LEN) || o_lose !== 1'b0) begin
          n_fail++;
          $display("FAIL win: win=%b round_len=%0d lose=%b, required 1 %0d 0",
                   o_win, o_round_len, o_lose, MAX_LEN);
        end
        rc_if.player_input = 1'b0;
      end else begin
        n_tests++;
        if (o_round_len !== 4'(len + 1) || rc_if.seq_counter !== 4'd0 || o_show_on !== 1'b0 ||
            o_win !== 1'b0) begin
          n_fail++;
          $display("FAIL grow len=%0d: round_len=%0d cnt=%0d show_on=%b win=%b, required %0d 0 0 0",
                   len, o_round_len, rc_if.seq_counter, o_show_on, o_win, len + 1);
        end
        rc_if.player_input = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (o_show_on !== 1'b0 || o_round_len !== 4'd1 || rc_if.seq_counter !== 4'd0 ||
        o_win !== 1'b0 || o_lose !== 1'b0 || rc_if.playerEN !== 1'b0 || rc_if.checkEN !== 1'b0) begin
      n_fail++;
      $display("FAIL por: show_on=%b len=%0d cnt=%0d win=%b lose=%b pEN=%b cEN=%b, required 0 1 0 0 0 0 0",
               o_show_on, o_round_len, rc_if.seq_counter, o_win, o_lose, rc_if.playerEN, rc_if.checkEN);
    end
    load_seq(2'b00, 1'b0);
    pulse_start();
    play_back(1);
    answer_round(1, -1);
    for (int i = 0; i <= GAP; i++) step();
    n_tests++;
    if (o_show_on !== 1'b1 || o_round_len !== 4'd2) begin
      n_fail++;
      $display("FAIL pre_reset_show: show_on=%b round_len=%0d, required 1 2", o_show_on, o_round_len);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (o_show_on !== 1'b0 || o_round_len !== 4'd1 || rc_if.seq_counter !== 4'd0 ||
        o_win !== 1'b0 || o_lose !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_show: show_on=%b len=%0d cnt=%0d win=%b lose=%b, required 0 1 0 0 0",
               o_show_on, o_round_len, rc_if.seq_counter, o_win, o_lose);
    end
    for (int i = 0; i < GAP + 2; i++) step();
    n_tests++;
    if (o_show_on !== 1'b0 || rc_if.playerEN !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: show_on=%b playerEN=%b, required 0 0", o_show_on, rc_if.playerEN);
    end
  endtask

  task automatic test_round_growth();
    do_reset();
    load_seq(2'b10, 1'b1);
    pulse_start();
    play_back(1);
    answer_round(1, -1);
    play_back(2);
    answer_round(2, -1);
    play_back(3);
  endtask

  task automatic test_wrong_tile();
    do_reset();
    load_seq(2'b00, 1'b0);
    pulse_start();
    for (int len = 1; len <= 2; len++) begin
      play_back(len);
      answer_round(len, -1);
    end
    play_back(3);
    answer_round(3, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (o_lose !== 1'b1 || rc_if.playerEN !== 1'b0 || rc_if.checkEN !== 1'b0 || o_show_on !== 1'b0) begin
        n_fail++;
        $display("FAIL lose_hold i=%0d: lose=%b pEN=%b cEN=%b show_on=%b, required 1 0 0 0",
                 i, o_lose, rc_if.playerEN, rc_if.checkEN, o_show_on);
      end
    end
    pulse_start();
    n_tests++;
    if (o_round_len !== 4'd1 || o_lose !== 1'b0 || o_win !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_after_lose: round_len=%0d lose=%b win=%b, required 1 0 0",
               o_round_len, o_lose, o_win);
    end
    play_back(1);
  endtask

  task automatic test_timeout();
    do_reset();
    load_seq(2'b00, 1'b0);
    pulse_start();
    play_back(1);
    for (int i = 0; i < TOUT; i++) begin
      n_tests++;
      if (rc_if.playerEN !== 1'b1 || o_lose !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait i=%0d: playerEN=%b lose=%b, required 1 0", i, rc_if.playerEN, o_lose);
      end
      i_start = (i == 5);
      step();
    end
    i_start = 1'b0;
    n_tests++;
    if (o_lose !== 1'b1 || rc_if.playerEN !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: lose=%b playerEN=%b, required 1 0", o_lose, rc_if.playerEN);
    end
  endtask

  task automatic test_tie();
    do_reset();
    load_seq(2'b00, 1'b0);
    pulse_start();
    play_back(1);
    press(0, TOUT - 1, 1'b1);
    rc_if.player_input = 1'b0;
    n_tests++;
    if (o_lose !== 1'b0 || o_round_len !== 4'd2) begin
      n_fail++;
      $display("FAIL tie: lose=%b round_len=%0d, required 0 2", o_lose, o_round_len);
    end
  endtask

  task automatic test_full_game();
    do_reset();
    load_seq(2'b00, 1'b0);
    pulse_start();
    for (int len = 1; len <= MAX_LEN; len++) begin
      play_back(len);
      answer_round(len, -1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (o_win !== 1'b1 || o_round_len !== 4'(MAX_LEN) || rc_if.playerEN !== 1'b0 || o_show_on !== 1'b0) begin
        n_fail++;
        $display("FAIL win_hold i=%0d: win=%b round_len=%0d pEN=%b show_on=%b, required 1 %0d 0 0",
                 i, o_win, o_round_len, rc_if.playerEN, o_show_on, MAX_LEN);
      end
    end
    pulse_start();
    n_tests++;
    if (o_win !== 1'b0 || o_round_len !== 4'd1) begin
      n_fail++;
      $display("FAIL restart_after_win: win=%b round_len=%0d, required 0 1", o_win, o_round_len);
    end
  endtask

  initial begin
    rc_if.player_input = 1'b0;
    rc_if.check = 1'b0;
    test_reset();
    test_round_growth();
    test_wrong_tile();
    test_timeout();
    test_tie();
    test_full_game();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
